// File: rtl/sprite_palette_lut_if.sv
// Pixel lookup, frame-timing and palette-write signals of sprite_palette_lut.
// The master drives indices and writes; the slave (the palette) returns colour.
interface sprite_palette_lut_if #(
  parameter int unsigned IDX_W = 4,
  parameter int unsigned CH_W  = 4,
  parameter int unsigned BANKS = 2
);
  localparam int unsigned BW = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic                in_valid;
  logic [IDX_W-1:0]    index;
  logic [BW-1:0]       bank_sel;
  logic                frame_start;
  logic                cycle_en;
  logic                wr_en;
  logic [BW-1:0]       wr_bank;
  logic [IDX_W-1:0]    wr_addr;
  logic [3*CH_W-1:0]   wr_data;
  logic                out_valid;
  logic [CH_W-1:0]     red;
  logic [CH_W-1:0]     green;
  logic [CH_W-1:0]     blue;
  logic                transparent;

  modport master (
    output in_valid, index, bank_sel, frame_start, cycle_en,
    output wr_en, wr_bank, wr_addr, wr_data,
    input  out_valid, red, green, blue, transparent
  );

  modport slave (
    input  in_valid, index, bank_sel, frame_start, cycle_en,
    input  wr_en, wr_bank, wr_addr, wr_data,
    output out_valid, red, green, blue, transparent
  );
endinterface

// File: rtl/sprite_palette_lut.sv
// Runtime-writable multi-bank sprite palette with a 2-stage lookup pipeline
// and per-frame colour cycling over an index range.
module sprite_palette_lut #(
  parameter int unsigned IDX_W      = 4,
  parameter int unsigned CH_W       = 4,
  parameter int unsigned BANKS      = 2,
  parameter int unsigned TRANSP_IDX = 0,
  parameter int unsigned CYC_LO     = 1,
  parameter int unsigned CYC_HI     = 10,
  parameter int unsigned CYC_DIV    = 8
) (
  input logic                 Clk,
  input logic                 Reset_n,
  sprite_palette_lut_if.slave bus
);

  localparam int unsigned SPAN    = CYC_HI - CYC_LO + 1;
  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned BW      = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int unsigned ROT_W   = (SPAN > 1) ? $clog2(SPAN) : 1;
  localparam int unsigned FC_W    = (CYC_DIV > 1) ? $clog2(CYC_DIV) : 1;
  localparam int unsigned IW1     = IDX_W + 1;
  localparam int unsigned RGB_W   = 3 * CH_W;

  localparam logic [IDX_W-1:0] CycLoIdx  = IDX_W'(CYC_LO);
  localparam logic [IDX_W-1:0] CycHiIdx  = IDX_W'(CYC_HI);
  localparam logic [IDX_W-1:0] TranspIdx = IDX_W'(TRANSP_IDX);
  localparam logic [IW1-1:0]   LoExt     = IW1'(CYC_LO);
  localparam logic [IW1-1:0]   SpanExt   = IW1'(SPAN);
  localparam logic [ROT_W-1:0] RotMax    = ROT_W'(SPAN - 1);
  localparam logic [FC_W-1:0]  FcMax     = FC_W'(CYC_DIV - 1);

  logic [RGB_W-1:0] pal_q [BANKS][ENTRIES];

  logic [ROT_W-1:0] rot_q, rot_d;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic             in_range;
  logic [IW1-1:0]   off;
  logic [IDX_W-1:0] eff_idx;
  logic [BW-1:0]    bank_d;
  logic             wr_ok;

  logic             s1_valid_q;
  logic [IDX_W-1:0] s1_idx_q;
  logic [BW-1:0]    s1_bank_q;
  logic             s1_transp_q;

  logic             out_valid_q;
  logic [RGB_W-1:0] rgb_q;
  logic             transp_q;

  // Rotate within [CYC_LO,CYC_HI]; both addends are below SPAN so one
  // conditional subtract is enough for the modulo.
  always_comb begin
    in_range = (bus.index >= CycLoIdx) && (bus.index <= CycHiIdx);
    off      = {1'b0, bus.index} - LoExt + IW1'(rot_q);
    if (off >= SpanExt) begin
      off = off - SpanExt;
    end
    eff_idx = in_range ? IDX_W'(off + LoExt) : bus.index;
    bank_d  = (32'(bus.bank_sel) < BANKS) ? bus.bank_sel : '0;
    wr_ok   = bus.wr_en && (32'(bus.wr_bank) < BANKS);
  end

  always_comb begin
    rot_d       = rot_q;
    frame_cnt_d = frame_cnt_q;
    if (bus.frame_start && bus.cycle_en) begin
      if (frame_cnt_q == FcMax) begin
        frame_cnt_d = '0;
        rot_d       = (rot_q == RotMax) ? '0 : rot_q + 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rot_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      rot_q       <= rot_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Non-blocking update gives read-before-write against the stage-2 lookup.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned b = 0; b < BANKS; b++) begin
        for (int unsigned e = 0; e < ENTRIES; e++) begin
          pal_q[b][e] <= '0;
        end
      end
    end else if (wr_ok) begin
      pal_q[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_bank_q   <= '0;
      s1_transp_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_idx_q    <= eff_idx;
        s1_bank_q   <= bank_d;
        s1_transp_q <= (bus.index == TranspIdx);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      out_valid_q <= 1'b0;
      rgb_q       <= '0;
      transp_q    <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        rgb_q    <= pal_q[s1_bank_q][s1_idx_q];
        transp_q <= s1_transp_q;
      end
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.red         = rgb_q[3*CH_W-1:2*CH_W];
  assign bus.green       = rgb_q[2*CH_W-1:CH_W];
  assign bus.blue        = rgb_q[CH_W-1:0];
  assign bus.transparent = transp_q;

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Directed bench for sprite_palette_lut, built with three banks so that an
// out-of-range bank select can be driven.
module tb_sprite_palette_lut;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CH_W  = 4;
  localparam int unsigned BANKS = 3;

  logic Clk = 1'b0;
  logic Reset_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 Clk = ~Clk;

  sprite_palette_lut_if #(.IDX_W(IDX_W), .CH_W(CH_W), .BANKS(BANKS)) bus ();

  sprite_palette_lut #(
    .IDX_W(IDX_W), .CH_W(CH_W), .BANKS(BANKS), .TRANSP_IDX(0),
    .CYC_LO(1), .CYC_HI(10), .CYC_DIV(8)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus.slave)
  );

  // {out_valid, transparent, red, green, blue}
  function automatic logic [13:0] obs();
    return {bus.out_valid, bus.transparent, bus.red, bus.green, bus.blue};
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic pix(input logic [3:0] idx, input logic [1:0] bank);
    bus.in_valid = 1'b1;
    bus.index    = idx;
    bus.bank_sel = bank;
  endtask

  task automatic wr(input logic [1:0] bank, input logic [3:0] addr, input logic [11:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_bank = bank;
    bus.wr_addr = addr;
    bus.wr_data = data;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [3:0] idx, input logic [1:0] bank,
                          input logic [11:0] rgb, input logic t);
    pix(idx, bank);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check(tag, 32'(obs()), 32'({1'b1, t, rgb}));
  endtask

  task automatic frames(input int n, input logic en);
    bus.cycle_en = en;
    repeat (n) begin
      bus.frame_start = 1'b1;
      tick();
      bus.frame_start = 1'b0;
    end
  endtask

  initial begin
    Reset_n         = 1'b1;
    bus.in_valid    = 1'b0;
    bus.index       = '0;
    bus.bank_sel    = '0;
    bus.frame_start = 1'b0;
    bus.cycle_en    = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_bank     = '0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    #2 Reset_n = 1'b0;
    tick();
    tick();
    check("reset_outputs", 32'(obs()), 32'h0);
    Reset_n = 1'b1;
    tick();

    // Basic lookup and latency
    wr(2'd0, 4'd3, 12'hF00);
    read_chk("b0_idx3", 4'd3, 2'd0, 12'hF00, 1'b0);

    // Back-to-back banks
    wr(2'd1, 4'd3, 12'h0AF);
    pix(4'd3, 2'd0);
    tick();
    pix(4'd3, 2'd1);
    tick();
    check("b2b_first", 32'(obs()), 32'({2'b10, 12'hF00}));
    bus.in_valid = 1'b0;
    tick();
    check("b2b_second", 32'(obs()), 32'({2'b10, 12'h0AF}));
    tick();
    check("idle_hold", 32'(obs()), 32'({2'b00, 12'h0AF}));

    // Transparent index
    wr(2'd0, 4'd0, 12'h123);
    read_chk("transp_idx0", 4'd0, 2'd0, 12'h123, 1'b1);

    // Entry i = {i, 15-i, 5}
    for (int i = 0; i < 16; i++) begin
      wr(2'd0, 4'(i), {4'(i), 4'(15 - i), 4'h5});
    end
    read_chk("rot0_idx10", 4'd10, 2'd0, 12'hA55, 1'b0);
    frames(7, 1'b1);
    read_chk("rot0_after7", 4'd10, 2'd0, 12'hA55, 1'b0);
    frames(1, 1'b1);
    read_chk("rot1_idx10", 4'd10, 2'd0, 12'h1E5, 1'b0);
    read_chk("rot1_idx4", 4'd4, 2'd0, 12'h5A5, 1'b0);
    read_chk("rot1_idx0_transp", 4'd0, 2'd0, 12'h0F5, 1'b1);
    read_chk("rot1_idx11_out", 4'd11, 2'd0, 12'hB45, 1'b0);
    read_chk("rot1_idx15_out", 4'd15, 2'd0, 12'hF05, 1'b0);
    frames(8, 1'b0);
    read_chk("cyc_off_hold", 4'd10, 2'd0, 12'h1E5, 1'b0);
    frames(64, 1'b1);
    read_chk("rot9_idx10", 4'd10, 2'd0, 12'h965, 1'b0);
    read_chk("rot9_idx1", 4'd1, 2'd0, 12'hA55, 1'b0);
    frames(8, 1'b1);
    read_chk("rot_wrap_idx10", 4'd10, 2'd0, 12'hA55, 1'b0);

    // frame_cnt holds while disabled; rot change only hits later pixels
    frames(4, 1'b1);
    frames(8, 1'b0);
    read_chk("fc_hold", 4'd10, 2'd0, 12'hA55, 1'b0);
    frames(3, 1'b1);
    bus.frame_start = 1'b1;
    pix(4'd10, 2'd0);
    tick();
    bus.frame_start = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("inflight_old_rot", 32'(obs()), 32'({2'b10, 12'hA55}));
    tick();
    check("next_new_rot", 32'(obs()), 32'({2'b10, 12'h1E5}));

    // Read-before-write on an entry outside the cycle range
    pix(4'd12, 2'd0);
    tick();
    bus.wr_en   = 1'b1;
    bus.wr_bank = 2'd0;
    bus.wr_addr = 4'd12;
    bus.wr_data = 12'hDEF;
    tick();
    bus.wr_en    = 1'b0;
    bus.in_valid = 1'b0;
    check("rbw_old", 32'(obs()), 32'({2'b10, 12'hC35}));
    tick();
    check("rbw_new", 32'(obs()), 32'({2'b10, 12'hDEF}));

    // Bank range handling
    wr(2'd3, 4'd12, 12'h999);
    read_chk("wr_bank3_ignored", 4'd12, 2'd0, 12'hDEF, 1'b0);
    read_chk("sel3_to_bank0", 4'd12, 2'd3, 12'hDEF, 1'b0);
    read_chk("bank2_empty", 4'd12, 2'd2, 12'h000, 1'b0);
    wr(2'd2, 4'd12, 12'h777);
    read_chk("bank2_write", 4'd12, 2'd2, 12'h777, 1'b0);

    // Reset mid-stream
    pix(4'd12, 2'd0);
    tick();
    tick();
    check("pre_reset_valid", 32'(obs()), 32'({2'b10, 12'hDEF}));
    Reset_n = 1'b0;
    #1;
    check("async_reset_clear", 32'(obs()), 32'h0);
    bus.in_valid = 1'b0;
    tick();
    Reset_n = 1'b1;
    tick();
    check("post_reset_idle", 32'(obs()), 32'h0);
    read_chk("table_cleared", 4'd12, 2'd0, 12'h000, 1'b0);
    wr(2'd0, 4'd10, 12'hABC);
    wr(2'd0, 4'd1, 12'h111);
    read_chk("rot_reset_zero", 4'd10, 2'd0, 12'hABC, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
